imem_loader: RTL and testbench

Writer side of the instruction memory: accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It drives the write port of the 64-word instruction RAM that the fetch path reads through `PC[7:2]`. While a load is in progress it holds the CPU off through `cpu_hold`. It lets programs be loaded at run time instead of being fixed at elaboration.

---
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the 64-word instruction RAM: packs big-endian words and holds the core while loading.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FIN = 2'd2, CHECK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FIN = 2'd2} state_t;
`endif

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_WORDS);

  state_t              state, state_d;
  logic [1:0]          byte_cnt;
  logic [ADDR_W-1:0]   word_idx;
  logic [ADDR_W:0]     nwords_q;
  logic [23:0]         asm_q;

  logic                xfer, start_ok, word_end, last_word, last_byte;
  logic                in_ready_d, imem_we_d, cpu_hold_d, busy_d, done_d, error_d;
  logic [ADDR_W-1:0]   imem_addr_d;
  logic [31:0]         imem_wdata_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  assign xfer      = in_valid & in_ready;
  assign start_ok  = start && (num_words != '0) && (num_words <= DEPTH_L);
  assign word_end  = (state == LOAD) && xfer && (byte_cnt == 2'd3);
  assign last_word = (({1'b0, word_idx} + (ADDR_W+1)'(1)) == nwords_q);
  assign last_byte = word_end && last_word;

  // next state
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start_ok) state_d = LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      LOAD:  if (last_byte) state_d = CHECK;
      CHECK: if (xfer) state_d = FIN;
`else
      // in_ready low in LOAD means the last word's write is going out this cycle
      LOAD: if (!in_ready) state_d = FIN;
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    imem_we_d    = word_end;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    if (word_end) begin
      imem_addr_d  = word_idx;
      imem_wdata_d = {asm_q, in_data};
    end
    in_ready_d = (state_d == LOAD) && !last_byte;
    cpu_hold_d = (state_d == LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_d == CHECK) begin
      in_ready_d = 1'b1;
      cpu_hold_d = 1'b1;
    end
`endif
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN) || ((state == IDLE) && start && (num_words == '0));
    error_d = error;
    if (state == IDLE && start) begin
      if (num_words > DEPTH_L) error_d = 1'b1;
      else if (start_ok)       error_d = 1'b0;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state == CHECK && xfer && (in_data != csum_q)) error_d = 1'b1;
`endif
  end

  // state, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_idx   <= '0;
      nwords_q   <= '0;
      asm_q      <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_d;
      in_ready   <= in_ready_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      cpu_hold   <= cpu_hold_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      if (state == IDLE && start_ok) begin
        nwords_q <= num_words;
        byte_cnt <= '0;
        word_idx <= '0;
        asm_q    <= '0;
      end else if (state == LOAD && xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_q    <= {asm_q[15:0], in_data};
        // index parks on the last word rather than wrapping past the RAM
        if (byte_cnt == 2'd3 && !last_word) word_idx <= word_idx + 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          csum_q <= '0;
    else if (state == IDLE && start_ok) csum_q <= '0;
    else if (state == LOAD && xfer)     csum_q <= csum_q ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write sequence, handshake timing, boundary counts, reset and checksum.
module tb_imem_loader;
  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [6:0]  num_words;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_hold, busy, done, error;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_done = 0;
  int n_hold = 0;
  int done_cyc = 0;
  logic [5:0]  wa [$];
  logic [31:0] wd [$];
  int          wc [$];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (cpu_hold) n_hold++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin in_valid = 1'b0; step(); end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("ready_stall", 32'(n), 32'd0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_load(input int n, input bq_t b, input bit gap, input int mid_at, output int c0);
    logic [7:0] x;
    x = 8'h00;
    start = 1'b1; num_words = 7'(n);
    step();
    start = 1'b0;
    c0 = cyc;
    for (int i = 0; i < b.size(); i++) begin
      if (i == mid_at) begin start = 1'b1; num_words = 7'd1; end
      push(b[i], gap);
      start = 1'b0;
      x = x ^ b[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    push(x, gap);
`endif
  endtask

  initial begin
    bq_t b1, b3, b4, b5;
    int c0, base, d0, h0;
    b1 = '{8'h8C, 8'h08, 8'h00, 8'h01, 8'h01, 8'h08, 8'h48, 8'h00};
    b4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE};
    b5 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 256; i++) b3.push_back(8'(i));

    reset = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b0; in_data = '0;
    #3;
    chk("rst_ready", in_ready, 0);   chk("rst_we", imem_we, 0);
    chk("rst_hold", cpu_hold, 0);    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);        chk("rst_err", error, 0);
    chk("rst_addr", imem_addr, 0);   chk("rst_wdata", imem_wdata, 0);
    step(); step();
    reset = 1'b0;
    step();

    // N=2, continuous valid
    base = wa.size(); d0 = n_done; h0 = n_hold;
    start = 1'b1; num_words = 7'd2;
    step();
    start = 1'b0;
    chk("t1_ready_up", in_ready, 1); chk("t1_hold_up", cpu_hold, 1); chk("t1_busy_up", busy, 1);
    c0 = cyc;
    for (int i = 0; i < 8; i++) push(b1[i], 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push(8'h8C ^ 8'h08 ^ 8'h01 ^ 8'h01 ^ 8'h08 ^ 8'h48, 1'b0);
`else
    chk("t1_last_rdy", in_ready, 0); chk("t1_last_we", imem_we, 1);
    chk("t1_last_hold", cpu_hold, 1);
    step();
    chk("t1_fin_done", done, 1); chk("t1_fin_hold", cpu_hold, 0); chk("t1_fin_busy", busy, 1);
    step();
    chk("t1_idle_busy", busy, 0); chk("t1_idle_done", done, 0);
`endif
    repeat (4) step();
    chk("t1_nwr", wa.size() - base, 2);
    chk("t1_a0", wa[base], 0);   chk("t1_d0", wd[base], 32'h8C080001);   chk("t1_c0", wc[base], c0 + 4);
    chk("t1_a1", wa[base+1], 1); chk("t1_d1", wd[base+1], 32'h01084800); chk("t1_c1", wc[base+1], c0 + 8);
    chk("t1_done_cyc", done_cyc, c0 + 9);
    chk("t1_ndone", n_done - d0, 1);
    chk("t1_nhold", n_hold - h0, 9);

    // same load, valid toggling
    base = wa.size(); d0 = n_done;
    run_load(2, b1, 1'b1, -1, c0);
    repeat (4) step();
    chk("t2_nwr", wa.size() - base, 2);
    chk("t2_a0", wa[base], 0);   chk("t2_d0", wd[base], 32'h8C080001);
    chk("t2_a1", wa[base+1], 1); chk("t2_d1", wd[base+1], 32'h01084800);
    chk("t2_ndone", n_done - d0, 1);

    // zero count
    base = wa.size();
    start = 1'b1; num_words = 7'd0;
    step();
    start = 1'b0;
    chk("t3_z_done", done, 1); chk("t3_z_busy", busy, 0); chk("t3_z_rdy", in_ready, 0);
    step();
    chk("t3_z_done_off", done, 0);
    repeat (2) step();
    chk("t3_z_nwr", wa.size() - base, 0);

    // over-range count
    start = 1'b1; num_words = 7'd65;
    step();
    start = 1'b0;
    chk("t3_o_err", error, 1); chk("t3_o_busy", busy, 0);
    chk("t3_o_rdy", in_ready, 0); chk("t3_o_done", done, 0);
    step();
    chk("t3_o_busy2", busy, 0); chk("t3_o_hold", cpu_hold, 0);

    // full depth
    base = wa.size();
    start = 1'b1; num_words = 7'd64;
    step();
    start = 1'b0;
    chk("t3_f_err_clr", error, 0);
    c0 = cyc;
    for (int i = 0; i < 256; i++) push(b3[i], 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push(8'h00, 1'b0);
`endif
    repeat (4) step();
    chk("t3_f_nwr", wa.size() - base, 64);
    chk("t3_f_d0", wd[base], 32'h00010203);
    chk("t3_f_alast", wa[base+63], 63);
    chk("t3_f_dlast", wd[base+63], 32'hFCFDFEFF);
    chk("t3_f_clast", wc[base+63], c0 + 256);
    chk("t3_f_err", error, 0);

    // reset after 6 bytes
    base = wa.size();
    start = 1'b1; num_words = 7'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) push(b4[i], 1'b0);
    reset = 1'b1;
    #1;
    chk("t4_ready", in_ready, 0); chk("t4_we", imem_we, 0);
    chk("t4_hold", cpu_hold, 0);  chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);      chk("t4_err", error, 0);
    chk("t4_addr", imem_addr, 0); chk("t4_wdata", imem_wdata, 0);
    step();
    reset = 1'b0;
    step();
    chk("t4_nwr", wa.size() - base, 1);
    chk("t4_a0", wa[base], 0);
    chk("t4_d0", wd[base], 32'hDEADBEEF);
    run_load(1, b5, 1'b0, -1, c0);
    repeat (4) step();
    chk("t4_fresh_nwr", wa.size() - base, 2);
    chk("t4_fresh_a", wa[base+1], 0);
    chk("t4_fresh_d", wd[base+1], 32'h11223344);

    // start pulsed mid-load
    base = wa.size(); d0 = n_done;
    run_load(2, b1, 1'b0, 2, c0);
    repeat (4) step();
    chk("t5_nwr", wa.size() - base, 2);
    chk("t5_d0", wd[base], 32'h8C080001);
    chk("t5_a1", wa[base+1], 1);
    chk("t5_d1", wd[base+1], 32'h01084800);
    chk("t5_c1", wc[base+1], c0 + 8);
    chk("t5_ndone", n_done - d0, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // checksum good then bad
    base = wa.size(); d0 = n_done;
    start = 1'b1; num_words = 7'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) push(b1[i], 1'b0);
    push(8'h85, 1'b0);
    chk("t6_g_done", done, 1); chk("t6_g_err", error, 0);
    repeat (3) step();
    start = 1'b1; num_words = 7'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) push(b1[i], 1'b0);
    push(8'h00, 1'b0);
    chk("t6_b_done", done, 1); chk("t6_b_err", error, 1);
    repeat (3) step();
    chk("t6_nwr", wa.size() - base, 2);
    chk("t6_d0", wd[base], 32'h8C080001);
    chk("t6_d1", wd[base+1], 32'h8C080001);
    chk("t6_ndone", n_done - d0, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
